// File: rtl/isp_program_loader_if.sv
// Byte-stream input and ISP/core-control output bundle of the program loader.
// The master modport is the loader; the slave modport is the UART/core side.
interface isp_program_loader_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    isp_write;
  logic [ADDRESS_BITS-1:0] isp_address;
  logic [DATA_WIDTH-1:0]   isp_data;
  logic                    core_reset;
  logic                    start;
  logic [19:0]             prog_address;
  logic                    busy;
  logic                    load_error;
  logic [ADDRESS_BITS:0]   words_loaded;

  modport master (
    input  rx_data, rx_valid,
    output isp_write, isp_address, isp_data, core_reset, start,
           prog_address, busy, load_error, words_loaded
  );

  modport slave (
    output rx_data, rx_valid,
    input  isp_write, isp_address, isp_data, core_reset, start,
           prog_address, busy, load_error, words_loaded
  );
endinterface

// File: rtl/isp_program_loader.sv
// Parses a framed UART byte stream (count, LE data words, XOR checksum), writes
// program memory through the ISP port, then releases and starts the core.
module isp_program_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12,
  parameter logic [19:0] BASE_ADDRESS = 20'h00000,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  isp_program_loader_if.master bus
);
  localparam int unsigned IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WL_W   = ADDRESS_BITS + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1 << ADDRESS_BITS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_DATA, S_CHECK, S_LAUNCH
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [15:0]             r_cnt, w_cnt_nxt;
  logic [7:0]              r_chk, w_chk_nxt;
  logic [23:0]             r_word, w_word_nxt;
  logic [1:0]              r_lane, w_lane_nxt;
  logic [IDLE_W-1:0]       r_idle, w_idle_nxt;
  logic                    r_isp_write, w_isp_write_nxt;
  logic [ADDRESS_BITS-1:0] r_isp_address, w_isp_address_nxt;
  logic [DATA_WIDTH-1:0]   r_isp_data, w_isp_data_nxt;
  logic                    r_core_reset, w_core_reset_nxt;
  logic                    r_start, w_start_nxt;
  logic [19:0]             r_prog_address, w_prog_address_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_load_error, w_load_error_nxt;
  logic [WL_W-1:0]         r_words_loaded, w_words_loaded_nxt;
  logic [15:0]             w_n;
  logic                    w_abort;

  assign w_n = {bus.rx_data, r_cnt[7:0]};

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_chk_nxt          = r_chk;
    w_word_nxt         = r_word;
    w_lane_nxt         = r_lane;
    w_idle_nxt         = r_idle;
    w_isp_write_nxt    = 1'b0;
    w_isp_address_nxt  = r_isp_address;
    w_isp_data_nxt     = r_isp_data;
    w_core_reset_nxt   = r_core_reset;
    w_start_nxt        = 1'b0;
    w_prog_address_nxt = r_prog_address;
    w_busy_nxt         = r_busy;
    w_load_error_nxt   = r_load_error;
    w_words_loaded_nxt = r_words_loaded;
    w_abort            = 1'b0;

    case (r_state)
      S_IDLE, S_LAUNCH: begin
        w_state_nxt = S_IDLE;
        if (bus.rx_valid) begin
          w_state_nxt        = S_CNT_HI;
          w_cnt_nxt          = {8'h00, bus.rx_data};
          w_chk_nxt          = bus.rx_data;
          w_lane_nxt         = 2'd0;
          w_idle_nxt         = '0;
          w_load_error_nxt   = 1'b0;
          w_words_loaded_nxt = '0;
          w_busy_nxt         = 1'b1;
          w_core_reset_nxt   = 1'b1;
        end
      end
      S_CNT_HI, S_DATA, S_CHECK: begin
        if (!bus.rx_valid) begin
          if (r_idle == IDLE_LAST) w_abort = 1'b1;
          else                     w_idle_nxt = r_idle + IDLE_W'(1);
        end else begin
          w_idle_nxt = '0;
          w_chk_nxt  = r_chk ^ bus.rx_data;
          if (r_state == S_CNT_HI) begin
            w_cnt_nxt = w_n;
            if ({1'b0, w_n} > MAX_WORDS) w_abort     = 1'b1;
            else if (w_n == 16'd0)       w_state_nxt = S_CHECK;
            else                         w_state_nxt = S_DATA;
          end else if (r_state == S_DATA) begin
            w_lane_nxt = r_lane + 2'd1;
            case (r_lane)
              2'd0:    w_word_nxt[7:0]   = bus.rx_data;
              2'd1:    w_word_nxt[15:8]  = bus.rx_data;
              2'd2:    w_word_nxt[23:16] = bus.rx_data;
              default: begin
                // Word completes on its lane-3 byte; the next byte may land next cycle.
                w_isp_write_nxt    = 1'b1;
                w_isp_address_nxt  = r_words_loaded[ADDRESS_BITS-1:0];
                w_isp_data_nxt     = DATA_WIDTH'({bus.rx_data, r_word});
                w_words_loaded_nxt = r_words_loaded + WL_W'(1);
                if ((16'(r_words_loaded) + 16'd1) == r_cnt) w_state_nxt = S_CHECK;
              end
            endcase
          end else begin
            if (bus.rx_data == r_chk) begin
              w_state_nxt        = S_LAUNCH;
              w_start_nxt        = 1'b1;
              w_core_reset_nxt   = 1'b0;
              w_prog_address_nxt = BASE_ADDRESS;
              w_busy_nxt         = 1'b0;
            end else begin
              w_abort = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort leaves the core held in reset; already-written words stay in memory.
    if (w_abort) begin
      w_state_nxt      = S_IDLE;
      w_load_error_nxt = 1'b1;
      w_busy_nxt       = 1'b0;
      w_idle_nxt       = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_chk          <= '0;
      r_word         <= '0;
      r_lane         <= '0;
      r_idle         <= '0;
      r_isp_write    <= 1'b0;
      r_isp_address  <= '0;
      r_isp_data     <= '0;
      r_core_reset   <= 1'b1;
      r_start        <= 1'b0;
      r_prog_address <= BASE_ADDRESS;
      r_busy         <= 1'b0;
      r_load_error   <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_chk          <= w_chk_nxt;
      r_word         <= w_word_nxt;
      r_lane         <= w_lane_nxt;
      r_idle         <= w_idle_nxt;
      r_isp_write    <= w_isp_write_nxt;
      r_isp_address  <= w_isp_address_nxt;
      r_isp_data     <= w_isp_data_nxt;
      r_core_reset   <= w_core_reset_nxt;
      r_start        <= w_start_nxt;
      r_prog_address <= w_prog_address_nxt;
      r_busy         <= w_busy_nxt;
      r_load_error   <= w_load_error_nxt;
      r_words_loaded <= w_words_loaded_nxt;
    end
  end

  assign bus.isp_write    = r_isp_write;
  assign bus.isp_address  = r_isp_address;
  assign bus.isp_data     = r_isp_data;
  assign bus.core_reset   = r_core_reset;
  assign bus.start        = r_start;
  assign bus.prog_address = r_prog_address;
  assign bus.busy         = r_busy;
  assign bus.load_error   = r_load_error;
  assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_isp_program_loader.sv
// Scoreboard bench for isp_program_loader: stimulus queues expected ISP writes and
// start pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_isp_program_loader;
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wr_t        exp_wr[$];
  int         exp_start[$];
  logic [7:0] frm[$];

  isp_program_loader_if #(.DATA_WIDTH(32), .ADDRESS_BITS(12)) bus ();

  isp_program_loader #(
    .DATA_WIDTH(32), .ADDRESS_BITS(12), .BASE_ADDRESS(20'h00000), .TIMEOUT(1024)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write or start the DUT presents must match the scoreboard head.
  always @(negedge clock) begin
    if (!reset && bus.isp_write) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", 64'(bus.isp_address), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("write_addr", 64'(bus.isp_address), 64'(e.addr));
        check("write_data", 64'(bus.isp_data), 64'(e.data));
      end
    end
    if (!reset && bus.start) begin
      if (exp_start.size() == 0) begin
        check("unexpected_start", 64'(bus.start), 64'h0);
      end else begin
        int wl;
        wl = exp_start.pop_front();
        check("start_prog_address", 64'(bus.prog_address), 64'h0);
        check("start_core_reset", 64'(bus.core_reset), 64'h0);
        check("start_busy", 64'(bus.busy), 64'h0);
        check("start_words_loaded", 64'(bus.words_loaded), 64'(wl));
      end
    end
  end

  task automatic send_frame(input int gap);
    foreach (frm[i]) begin
      bus.rx_data  = frm[i];
      bus.rx_valid = 1'b1;
      @(posedge clock); #1;
      if (gap > 0) begin
        bus.rx_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_prog_a();
    exp_wr.push_back('{addr: 12'd0, data: 32'h0000_0013});
    exp_wr.push_back('{addr: 12'd1, data: 32'h0000_006F});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_isp_write"}, 64'(bus.isp_write), 64'h0);
    check({tag, "_isp_address"}, 64'(bus.isp_address), 64'h0);
    check({tag, "_isp_data"}, 64'(bus.isp_data), 64'h0);
    check({tag, "_core_reset"}, 64'(bus.core_reset), 64'h1);
    check({tag, "_start"}, 64'(bus.start), 64'h0);
    check({tag, "_prog_address"}, 64'(bus.prog_address), 64'h0);
    check({tag, "_busy"}, 64'(bus.busy), 64'h0);
    check({tag, "_load_error"}, 64'(bus.load_error), 64'h0);
    check({tag, "_words_loaded"}, 64'(bus.words_loaded), 64'h0);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check_reset_values("por");

    // Good two-word frame, back-to-back bytes.
    push_prog_a();
    exp_start.push_back(2);
    frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_frame(0);
    idle(3);
    check("ok_load_error", 64'(bus.load_error), 64'h0);
    check("ok_core_reset", 64'(bus.core_reset), 64'h0);
    check("ok_words_loaded", 64'(bus.words_loaded), 64'd2);

    // Bad checksum: writes happen, no start, error sticky until next frame.
    push_prog_a();
    frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7F};
    send_frame(0);
    idle(3);
    check("badchk_load_error", 64'(bus.load_error), 64'h1);
    check("badchk_core_reset", 64'(bus.core_reset), 64'h1);
    check("badchk_busy", 64'(bus.busy), 64'h0);
    frm = '{8'h00};
    send_frame(0);
    check("newframe_clears_error", 64'(bus.load_error), 64'h0);
    check("newframe_busy", 64'(bus.busy), 64'h1);

    // Empty frame completes with a start and zero words.
    exp_start.push_back(0);
    frm = '{8'h00, 8'h00};
    send_frame(0);
    idle(3);
    check("empty_core_reset", 64'(bus.core_reset), 64'h0);
    check("empty_words_loaded", 64'(bus.words_loaded), 64'd0);

    // N = 4097 exceeds memory: abort right after the count.
    frm = '{8'h01, 8'h10};
    send_frame(0);
    idle(2);
    check("toolong_load_error", 64'(bus.load_error), 64'h1);
    check("toolong_busy", 64'(bus.busy), 64'h0);
    check("toolong_core_reset", 64'(bus.core_reset), 64'h1);

    // Following bytes form a fresh frame; spaced 3 cycles apart.
    push_prog_a();
    exp_start.push_back(2);
    frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7E};
    send_frame(3);
    idle(3);
    check("spaced_load_error", 64'(bus.load_error), 64'h0);
    check("spaced_words_loaded", 64'(bus.words_loaded), 64'd2);

    // Silence mid-DATA trips the idle timeout.
    frm = '{8'h01, 8'h00, 8'hAA};
    send_frame(0);
    idle(1000);
    check("timeout_pending_busy", 64'(bus.busy), 64'h1);
    idle(40);
    check("timeout_busy", 64'(bus.busy), 64'h0);
    check("timeout_load_error", 64'(bus.load_error), 64'h1);
    check("timeout_core_reset", 64'(bus.core_reset), 64'h1);

    // Synchronous reset mid-DATA discards the partial frame.
    frm = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_frame(0);
    check("prereset_busy", 64'(bus.busy), 64'h1);
    reset = 1'b1;
    idle(1);
    check_reset_values("midreset");
    reset = 1'b0;

    exp_start.push_back(0);
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    idle(3);
    check("postreset_core_reset", 64'(bus.core_reset), 64'h0);

    idle(5);
    check("writes_outstanding", 64'(exp_wr.size()), 64'h0);
    check("starts_outstanding", 64'(exp_start.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
